vga_scene_renderer: RTL and testbench
=====================================

VGA_SCENE_RENDERER -- requirements
Module: vga_scene_renderer

Interface
REQ-001 Parameters SHALL be: NUM_PIPES, default 4, number of pipe channels; PIPE_W, default 80, pipe width in px; GAP_H, default 100, vertical gap height in px; BIRD_HALF, default 10, bird half-size in px; CW, default 10, coordinate width.
REQ-002 The design SHALL use one clock, and reset SHALL be synchronous and active-high. The ports are clk (input, 1, system clock) and reset (input, 1, synchronous active-high reset).
REQ-003 Port pix_en SHALL be input, 1 bit: pixel-rate enable, one clk cycle wide.
REQ-004 Ports bird_x and bird_y SHALL be inputs, CW bits each: bird centre.
REQ-005 Port pipe_x SHALL be input, NUM_PIPES*CW bits: packed left edges, with channel i at [i*CW +: CW].
REQ-006 Port pipe_y SHALL be input, NUM_PIPES*CW bits: packed gap-top rows.
REQ-007 Port pipe_valid SHALL be input, NUM_PIPES bits: per-channel draw and collide enable.
REQ-008 Port collision_clr SHALL be input, 1 bit: clear for the sticky collision flag.
REQ-009 Ports vga_h_sync and vga_v_sync SHALL be outputs, 1 bit each, active low.
REQ-010 Ports vga_r, vga_g and vga_b SHALL be outputs, 1 bit each, registered.
REQ-011 Port frame_start SHALL be output, 1 bit: one-clk pulse.
REQ-012 Port collision SHALL be output, 1 bit: sticky flag.

Function
REQ-013 Timing counters hcnt (0..799) and vcnt (0..524) SHALL advance only on pix_en cycles. hcnt wraps 799->0; vcnt increments on hcnt wrap and wraps 524->0.
REQ-014 Horizontal timing SHALL be 640 visible, 16 front porch, 96 sync, 48 back porch. Sync is low for hcnt 656..751.
REQ-015 Vertical timing SHALL be 480 visible, 10 front porch, 2 sync, 33 back porch. Sync is low for vcnt 490..491.
REQ-016 Shadow registers SHALL capture all bird and pipe inputs on the pix_en cycle where hcnt=0 and vcnt=480. Rendering uses only shadow values, so there is no mid-frame tearing.
REQ-017 frame_start SHALL pulse for one clk on the same cycle as the shadow capture.
REQ-018 Bird box bounds SHALL be computed with CW+1-bit arithmetic. The left bound is max(bird_x-BIRD_HALF, 0) and the right bound is min(bird_x+BIRD_HALF, 639). The top bound is max(bird_y-BIRD_HALF, 0) and the bottom bound is min(bird_y+BIRD_HALF, 479). All bounds are inclusive.
REQ-019 Pipe i SHALL cover pixels where pipe_valid[i]=1 and pipe_x[i] <= x <= min(pipe_x[i]+PIPE_W-1, 639), and also either y < pipe_y[i] or y >= pipe_y[i]+GAP_H. Comparisons use CW+1 bits, so there is no wrap.
REQ-020 Pixel priority SHALL be: outside the visible area gives r=g=b=0; bird gives r=1 only; pipe gives g=1 only; otherwise black.
REQ-021 Pipeline latency SHALL be 2 pix_en cycles: stage 1 registers the hit terms, stage 2 registers the RGB. The sync outputs are delayed by the same 2 stages so they stay aligned with the RGB.
REQ-022 collision SHALL be set on a stage-1 pix_en cycle where the pixel is visible and bird_hit is true and any pipe_hit is true.
REQ-023 collision SHALL be cleared by collision_clr. If set and clear occur on the same clk, set wins.
REQ-024 When pix_en=0, all registers except collision SHALL hold their values.

Reset
REQ-025 On reset, hcnt, vcnt, the pipeline stages, the shadow registers, vga_r/g/b, frame_start and collision SHALL all be 0, and vga_h_sync and vga_v_sync SHALL be 1.
REQ-026 A reset asserted mid-frame SHALL restart timing at (0,0) on the next clk. No partial frame state is retained.

Structure
REQ-027 Package vga_scene_pkg SHALL hold the constants H_VISIBLE, H_FP, H_SYNC, H_BP, V_VISIBLE, V_FP, V_SYNC and V_BP, the derived totals, and the screen max coordinates.
REQ-028 Sub-module vga_timing SHALL own hcnt, vcnt, the sync generation and the visible flag. The renderer instantiates it once; the per-pipe hit logic is a generate loop.

Verification
REQ-029 The bench SHALL cover all of the following directed scenarios:
- Frame timing: free-run pix_en every 2nd clk -> vga_h_sync low for 96 pix_en periods per 800, vga_v_sync low for 2 lines per 525, frame_start once per 420000 pix_en periods.
- Bird clamp: bird=(5,5), BIRD_HALF=10, no pipes -> red exactly at x 0..15, y 0..15; black elsewhere.
- Pipe gap: pipe0 valid x=600, y=200 -> green at x 600..639 for y<200 and y>=300; black at y 200..299; no wrap at x=0..39.
- Collision: bird=(620,150), pipe0 as above -> collision=1 during frame; collision_clr pulsed mid-frame without further overlap -> 0; set and clr on the same clk -> 1.
- Tearing: change pipe_x at vcnt=240 -> no RGB change until the frame after the next capture (hcnt=0, vcnt=480).
- Reset: assert reset at hcnt=300, vcnt=100 -> next clk all outputs at reset values; the frame restarts at (0,0).

Source files
------------

// File: rtl/vga_scene_pkg.sv
// Shared VGA 640x480@60 timing constants and pipeline record types for the
// scene renderer and its timing generator.
package vga_scene_pkg;

    // Horizontal timing in pixel clocks
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Inclusive sync windows (active low while inside)
    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // Largest on-screen coordinates
    localparam int X_MAX = H_VISIBLE - 1;
    localparam int Y_MAX = V_VISIBLE - 1;

    // Row on which the next frame's scene is latched (first blanking line)
    localparam int CAPTURE_LINE = V_VISIBLE;

    // Stage-1 record: hit terms plus the syncs that travel alongside them
    typedef struct packed {
        logic visible;
        logic bird_hit;
        logic pipe_hit;
        logic h_sync;
        logic v_sync;
    } stage1_t;

    // Idle value of the stage-1 record: black pixel, syncs inactive (high)
    localparam stage1_t STAGE1_IDLE = '{
        visible:  1'b0,
        bird_hit: 1'b0,
        pipe_hit: 1'b0,
        h_sync:   1'b1,
        v_sync:   1'b1
    };

endpackage

// File: rtl/vga_scene_renderer_timing.sv
// Raster counters, active-low sync decode and visible-area flag.
// Counters advance only on pixel-rate enable cycles.
module vga_timing
    import vga_scene_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt,
    output logic          h_sync,
    output logic          v_sync,
    output logic          visible
);

    logic [CW-1:0] hcnt_reg;
    logic [CW-1:0] vcnt_reg;
    logic          h_last;
    logic          v_last;

    assign h_last = (hcnt_reg == CW'(H_TOTAL - 1));
    assign v_last = (vcnt_reg == CW'(V_TOTAL - 1));

    // Raster position: pixel counter wraps each line, line counter each frame
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                hcnt_reg <= '0;
                if (v_last) begin
                    vcnt_reg <= '0;
                end else begin
                    vcnt_reg <= vcnt_reg + CW'(1);
                end
            end else begin
                hcnt_reg <= hcnt_reg + CW'(1);
            end
        end
    end

    // Sync and visible decode for the current raster position
    always_comb begin
        h_sync  = !((hcnt_reg >= CW'(H_SYNC_START)) && (hcnt_reg <= CW'(H_SYNC_END)));
        v_sync  = !((vcnt_reg >= CW'(V_SYNC_START)) && (vcnt_reg <= CW'(V_SYNC_END)));
        visible = (hcnt_reg < CW'(H_VISIBLE)) && (vcnt_reg < CW'(V_VISIBLE));
    end

    assign hcnt = hcnt_reg;
    assign vcnt = vcnt_reg;

endmodule

// File: rtl/vga_scene_renderer.sv
// Flappy-style scene renderer: one bird box over up to NUM_PIPES pipe
// channels on a 640x480 raster. Scene inputs are latched once per frame in
// vertical blanking so a frame never mixes old and new positions. Two
// pixel-enable stages (hit terms, then colour) with syncs delayed alongside.
module vga_scene_renderer
    import vga_scene_pkg::*;
#(
    parameter int NUM_PIPES = 4,
    parameter int PIPE_W    = 80,
    parameter int GAP_H     = 100,
    parameter int BIRD_HALF = 10,
    parameter int CW        = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pix_en,
    input  logic [CW-1:0]           bird_x,
    input  logic [CW-1:0]           bird_y,
    input  logic [NUM_PIPES*CW-1:0] pipe_x,
    input  logic [NUM_PIPES*CW-1:0] pipe_y,
    input  logic [NUM_PIPES-1:0]    pipe_valid,
    input  logic                    collision_clr,
    output logic                    vga_h_sync,
    output logic                    vga_v_sync,
    output logic                    vga_r,
    output logic                    vga_g,
    output logic                    vga_b,
    output logic                    frame_start,
    output logic                    collision
);

    // One extra bit so box edges never wrap around when adding offsets
    localparam int XW = CW + 1;

    // ---------------------------------------------------------------------
    // Raster timing
    // ---------------------------------------------------------------------
    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          h_sync_raw;
    logic          v_sync_raw;
    logic          visible;

    vga_timing #(
        .CW (CW)
    ) u_timing (
        .clk     (clk),
        .reset   (reset),
        .pix_en  (pix_en),
        .hcnt    (hcnt),
        .vcnt    (vcnt),
        .h_sync  (h_sync_raw),
        .v_sync  (v_sync_raw),
        .visible (visible)
    );

    // ---------------------------------------------------------------------
    // Per-frame scene snapshot
    // ---------------------------------------------------------------------
    logic                    capture;
    logic [CW-1:0]           bird_x_reg;
    logic [CW-1:0]           bird_y_reg;
    logic [NUM_PIPES*CW-1:0] pipe_x_reg;
    logic [NUM_PIPES*CW-1:0] pipe_y_reg;
    logic [NUM_PIPES-1:0]    pipe_valid_reg;

    assign capture = pix_en && (hcnt == CW'(0)) && (vcnt == CW'(CAPTURE_LINE));

    // Latch scene inputs at the start of vertical blanking only
    always_ff @(posedge clk) begin
        if (reset) begin
            bird_x_reg     <= '0;
            bird_y_reg     <= '0;
            pipe_x_reg     <= '0;
            pipe_y_reg     <= '0;
            pipe_valid_reg <= '0;
        end else if (capture) begin
            bird_x_reg     <= bird_x;
            bird_y_reg     <= bird_y;
            pipe_x_reg     <= pipe_x;
            pipe_y_reg     <= pipe_y;
            pipe_valid_reg <= pipe_valid;
        end
    end

    // Pulse marks the very cycle the snapshot is taken; gated so reset
    // never lets it through even if the raster happens to sit on the line
    assign frame_start = capture && !reset;

    // ---------------------------------------------------------------------
    // Hit detection on the current raster position
    // ---------------------------------------------------------------------
    logic [XW-1:0] px;
    logic [XW-1:0] py;
    logic [XW-1:0] bird_xe;
    logic [XW-1:0] bird_ye;
    logic [XW-1:0] bird_xs;
    logic [XW-1:0] bird_ys;
    logic [XW-1:0] bird_left;
    logic [XW-1:0] bird_right;
    logic [XW-1:0] bird_top;
    logic [XW-1:0] bird_bottom;
    logic          bird_hit;

    assign px      = {1'b0, hcnt};
    assign py      = {1'b0, vcnt};
    assign bird_xe = {1'b0, bird_x_reg};
    assign bird_ye = {1'b0, bird_y_reg};
    assign bird_xs = bird_xe + XW'(BIRD_HALF);
    assign bird_ys = bird_ye + XW'(BIRD_HALF);

    // Bird box, clamped to the screen so a bird near an edge is cut off
    always_comb begin
        bird_left   = (bird_xe >= XW'(BIRD_HALF)) ? (bird_xe - XW'(BIRD_HALF)) : '0;
        bird_top    = (bird_ye >= XW'(BIRD_HALF)) ? (bird_ye - XW'(BIRD_HALF)) : '0;
        bird_right  = (bird_xs > XW'(X_MAX)) ? XW'(X_MAX) : bird_xs;
        bird_bottom = (bird_ys > XW'(Y_MAX)) ? XW'(Y_MAX) : bird_ys;
        bird_hit    = (px >= bird_left) && (px <= bird_right) &&
                      (py >= bird_top)  && (py <= bird_bottom);
    end

    logic [NUM_PIPES-1:0] pipe_hit_vec;
    logic                 pipe_hit;

    // One comparator set per pipe channel: column span minus the open gap
    generate
        for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
            logic [XW-1:0] left;
            logic [XW-1:0] right_raw;
            logic [XW-1:0] right;
            logic [XW-1:0] gap_top;
            logic [XW-1:0] gap_bottom;
            logic          in_column;
            logic          in_solid;

            assign left       = {1'b0, pipe_x_reg[gi*CW +: CW]};
            assign right_raw  = left + XW'(PIPE_W - 1);
            assign right      = (right_raw > XW'(X_MAX)) ? XW'(X_MAX) : right_raw;
            assign gap_top    = {1'b0, pipe_y_reg[gi*CW +: CW]};
            assign gap_bottom = gap_top + XW'(GAP_H);
            assign in_column  = (px >= left) && (px <= right);
            assign in_solid   = (py < gap_top) || (py >= gap_bottom);

            assign pipe_hit_vec[gi] = pipe_valid_reg[gi] && in_column && in_solid;
        end
    endgenerate

    assign pipe_hit = |pipe_hit_vec;

    // ---------------------------------------------------------------------
    // Two-stage pixel pipeline
    // ---------------------------------------------------------------------
    stage1_t s1_reg;
    logic    vga_r_reg;
    logic    vga_g_reg;
    logic    vga_b_reg;
    logic    vga_h_sync_reg;
    logic    vga_v_sync_reg;

    // Stage 1: register hit terms together with the raw syncs
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg <= STAGE1_IDLE;
        end else if (pix_en) begin
            s1_reg.visible  <= visible;
            s1_reg.bird_hit <= bird_hit;
            s1_reg.pipe_hit <= pipe_hit;
            s1_reg.h_sync   <= h_sync_raw;
            s1_reg.v_sync   <= v_sync_raw;
        end
    end

    // Stage 2: resolve colour (bird over pipe over black), syncs follow
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_r_reg      <= 1'b0;
            vga_g_reg      <= 1'b0;
            vga_b_reg      <= 1'b0;
            vga_h_sync_reg <= 1'b1;
            vga_v_sync_reg <= 1'b1;
        end else if (pix_en) begin
            vga_r_reg      <= s1_reg.visible && s1_reg.bird_hit;
            vga_g_reg      <= s1_reg.visible && !s1_reg.bird_hit && s1_reg.pipe_hit;
            vga_b_reg      <= 1'b0;
            vga_h_sync_reg <= s1_reg.h_sync;
            vga_v_sync_reg <= s1_reg.v_sync;
        end
    end

    assign vga_r      = vga_r_reg;
    assign vga_g      = vga_g_reg;
    assign vga_b      = vga_b_reg;
    assign vga_h_sync = vga_h_sync_reg;
    assign vga_v_sync = vga_v_sync_reg;

    // ---------------------------------------------------------------------
    // Sticky collision flag
    // ---------------------------------------------------------------------
    logic collision_reg;
    logic collision_set;

    assign collision_set = pix_en && visible && bird_hit && pipe_hit;

    // Set has priority over clear so an overlap is never lost to a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            collision_reg <= 1'b0;
        end else if (collision_set) begin
            collision_reg <= 1'b1;
        end else if (collision_clr) begin
            collision_reg <= 1'b0;
        end
    end

    assign collision = collision_reg;

endmodule

// File: tb/tb_vga_scene_renderer.sv
// Directed bench for vga_scene_renderer: pix_en runs every 2nd clk, the
// bench keeps its own raster position and records each output pixel into a
// frame image, then compares counts and spot pixels with hand-worked values.
module tb_vga_scene_renderer;

    localparam int CW = 10;
    localparam int NP = 4;
    localparam int FRAME_TICKS = 800 * 525;

    logic             clk = 1'b0;
    logic             reset;
    logic             pix_en;
    logic [CW-1:0]    bird_x;
    logic [CW-1:0]    bird_y;
    logic [NP*CW-1:0] pipe_x;
    logic [NP*CW-1:0] pipe_y;
    logic [NP-1:0]    pipe_valid;
    logic             collision_clr;
    logic             vga_h_sync;
    logic             vga_v_sync;
    logic             vga_r;
    logic             vga_g;
    logic             vga_b;
    logic             frame_start;
    logic             collision;

    always #5 clk = ~clk;

    vga_scene_renderer #(
        .NUM_PIPES (NP),
        .PIPE_W    (80),
        .GAP_H     (100),
        .BIRD_HALF (10),
        .CW        (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pix_en        (pix_en),
        .bird_x        (bird_x),
        .bird_y        (bird_y),
        .pipe_x        (pipe_x),
        .pipe_y        (pipe_y),
        .pipe_valid    (pipe_valid),
        .collision_clr (collision_clr),
        .vga_h_sync    (vga_h_sync),
        .vga_v_sync    (vga_v_sync),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .frame_start   (frame_start),
        .collision     (collision)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Bench raster position (next pixel to be presented) and the pixel
    // whose colour is on the outputs after the following step
    int mh, mv, ph, pv;
    bit pvalid;

    int red_cnt, green_cnt, blue_cnt, hs_low, vs_low, hs_bad, vs_bad;
    int blank_bad, fs_cnt, fs_bad;

    bit img_r [480][640];
    bit img_g [480][640];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    task automatic clear_stats();
        red_cnt = 0; green_cnt = 0; blue_cnt = 0;
        hs_low = 0; vs_low = 0; hs_bad = 0; vs_bad = 0;
        blank_bad = 0; fs_cnt = 0; fs_bad = 0;
    endtask

    // One pix_en period (2 clks). clr_hi drives collision_clr on the pix_en
    // clk, clr_lo on the idle clk that follows.
    task automatic step(input bit clr_hi, input bit clr_lo);
        bit at_cap;
        bit in_vis;
        at_cap = (mh == 0) && (mv == 480);
        pix_en = 1'b1;
        collision_clr = clr_hi;
        #1;
        if (frame_start === 1'b1) fs_cnt++;
        if ((frame_start === 1'b1) != at_cap) fs_bad++;
        @(posedge clk); #1;
        pix_en = 1'b0;
        collision_clr = clr_lo;
        if (pvalid) begin
            in_vis = (ph < 640) && (pv < 480);
            if (in_vis) begin
                img_r[pv][ph] = vga_r;
                img_g[pv][ph] = vga_g;
                if (vga_r === 1'b1) red_cnt++;
                if (vga_g === 1'b1) green_cnt++;
            end else if (vga_r !== 1'b0 || vga_g !== 1'b0 || vga_b !== 1'b0) begin
                blank_bad++;
            end
            if (vga_b !== 1'b0) blue_cnt++;
            if (vga_h_sync === 1'b0) hs_low++;
            if (vga_v_sync === 1'b0) vs_low++;
            if ((vga_h_sync === 1'b0) != ((ph >= 656) && (ph <= 751))) hs_bad++;
            if ((vga_v_sync === 1'b0) != ((pv >= 490) && (pv <= 491))) vs_bad++;
        end
        ph = mh; pv = mv; pvalid = 1'b1;
        mh++;
        if (mh == 800) begin
            mh = 0;
            mv++;
            if (mv == 525) mv = 0;
        end
        @(posedge clk); #1;
        collision_clr = 1'b0;
    endtask

    task automatic run_to(input int h, input int v);
        while (!(mh == h && mv == v)) step(1'b0, 1'b0);
    endtask

    initial begin
        int n;
        reset = 1'b1; pix_en = 1'b1; collision_clr = 1'b0;
        bird_x = 10'd5; bird_y = 10'd5;
        pipe_x = '0; pipe_y = '0; pipe_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_r", vga_r, 0);
        check_eq("rst_g", vga_g, 0);
        check_eq("rst_b", vga_b, 0);
        check_eq("rst_hsync", vga_h_sync, 1);
        check_eq("rst_vsync", vga_v_sync, 1);
        check_eq("rst_frame_start", frame_start, 0);
        check_eq("rst_collision", collision, 0);
        pix_en = 1'b0;
        reset = 1'b0;
        mh = 0; mv = 0; pvalid = 1'b0;

        // First capture lands at pixel (0,480): 480*800 ticks, then that one
        clear_stats();
        n = 0;
        while (fs_cnt == 0 && n < 400000) begin
            step(1'b0, 1'b0);
            n++;
        end
        check_eq("first_capture_ticks", n, 384001);

        // Frame 1: bird (5,5) clamped at the top-left, no pipes
        clear_stats();
        bird_x = 10'd1000; bird_y = 10'd1000;
        pipe_x[0 +: CW] = 10'd600; pipe_y[0 +: CW] = 10'd200;
        pipe_valid = 4'b0001;
        repeat (FRAME_TICKS) step(1'b0, 1'b0);
        check_eq("f1_frame_start_count", fs_cnt, 1);
        check_eq("f1_frame_start_pos_err", fs_bad, 0);
        check_eq("f1_hsync_low", hs_low, 96 * 525);
        check_eq("f1_vsync_low", vs_low, 2 * 800);
        check_eq("f1_hsync_pos_err", hs_bad, 0);
        check_eq("f1_vsync_pos_err", vs_bad, 0);
        check_eq("f1_blank_err", blank_bad, 0);
        check_eq("f1_blue", blue_cnt, 0);
        check_eq("f1_red_count", red_cnt, 256);
        check_eq("f1_green_count", green_cnt, 0);
        check_eq("f1_r_0_0", img_r[0][0], 1);
        check_eq("f1_r_15_15", img_r[15][15], 1);
        check_eq("f1_r_y15_x16", img_r[15][16], 0);
        check_eq("f1_r_y16_x15", img_r[16][15], 0);

        // Frame 2: pipe0 at x=600 gap 200..299, bird off-screen
        clear_stats();
        bird_x = 10'd620; bird_y = 10'd150;
        repeat (FRAME_TICKS) step(1'b0, 1'b0);
        check_eq("f2_green_count", green_cnt, 40 * 380);
        check_eq("f2_red_count", red_cnt, 0);
        check_eq("f2_g_y0_x600", img_g[0][600], 1);
        check_eq("f2_g_y199_x639", img_g[199][639], 1);
        check_eq("f2_g_y200_x620", img_g[200][620], 0);
        check_eq("f2_g_y299_x620", img_g[299][620], 0);
        check_eq("f2_g_y300_x620", img_g[300][620], 1);
        check_eq("f2_g_y479_x639", img_g[479][639], 1);
        check_eq("f2_g_y100_x599", img_g[100][599], 0);
        check_eq("f2_g_y100_x0_nowrap", img_g[100][0], 0);
        check_eq("f2_g_y100_x39_nowrap", img_g[100][39], 0);
        check_eq("f2_collision", collision, 0);

        // Frame 3: bird (620,150) overlaps pipe; clear/set priority; tearing
        clear_stats();
        run_to(619, 150);
        step(1'b0, 1'b1);
        check_eq("f3_clr_idle_clk", collision, 0);
        step(1'b1, 1'b0);
        check_eq("f3_set_wins_over_clr", collision, 1);
        run_to(0, 240);
        check_eq("f3_collision_mid", collision, 1);
        pipe_x[0 +: CW] = 10'd100;
        run_to(0, 300);
        step(1'b0, 1'b1);
        check_eq("f3_collision_cleared", collision, 0);
        run_to(0, 480);
        step(1'b0, 1'b0);
        check_eq("f3_frame_start_count", fs_cnt, 1);
        check_eq("f3_collision_end", collision, 0);
        check_eq("f3_red_count", red_cnt, 441);
        check_eq("f3_green_count_no_tear", green_cnt, 15200 - 441);
        check_eq("f3_g_y400_x600_old", img_g[400][600], 1);
        check_eq("f3_g_y400_x100_new", img_g[400][100], 0);
        check_eq("f3_r_y150_x620", img_r[150][620], 1);

        // Frame 4: new pipe position takes effect, no overlap
        clear_stats();
        bird_x = 10'd150; bird_y = 10'd50;
        step(1'b0, 1'b1);
        run_to(0, 480);
        step(1'b0, 1'b0);
        check_eq("f4_frame_start_count", fs_cnt, 1);
        check_eq("f4_collision", collision, 0);
        check_eq("f4_green_count", green_cnt, 80 * 380);
        check_eq("f4_red_count", red_cnt, 441);
        check_eq("f4_g_y400_x100", img_g[400][100], 1);
        check_eq("f4_g_y400_x600", img_g[400][600], 0);
        check_eq("f4_g_y100_x179", img_g[100][179], 1);
        check_eq("f4_g_y100_x180", img_g[100][180], 0);
        check_eq("f4_g_y250_x150_gap", img_g[250][150], 0);

        // Frame 5: overlap near the top, then reset at (300,100)
        run_to(300, 100);
        check_eq("f5_collision_before_reset", collision, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_r", vga_r, 0);
        check_eq("mid_rst_g", vga_g, 0);
        check_eq("mid_rst_b", vga_b, 0);
        check_eq("mid_rst_hsync", vga_h_sync, 1);
        check_eq("mid_rst_vsync", vga_v_sync, 1);
        check_eq("mid_rst_frame_start", frame_start, 0);
        check_eq("mid_rst_collision", collision, 0);
        reset = 1'b0;
        mh = 0; mv = 0; pvalid = 1'b0;

        // Restart from (0,0) with cleared snapshot: bird at (0,0), no pipes
        clear_stats();
        repeat (12 * 800) step(1'b0, 1'b0);
        check_eq("post_rst_red_count", red_cnt, 121);
        check_eq("post_rst_green_count", green_cnt, 0);
        check_eq("post_rst_r_0_0", img_r[0][0], 1);
        check_eq("post_rst_r_10_10", img_r[10][10], 1);
        check_eq("post_rst_r_y0_x11", img_r[0][11], 0);
        check_eq("post_rst_r_y11_x0", img_r[11][0], 0);
        check_eq("post_rst_hsync_pos_err", hs_bad, 0);
        check_eq("post_rst_frame_start", fs_cnt, 0);
        check_eq("post_rst_collision", collision, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
